atm_balance_arbiter: RTL and testbench

Shares the single account balance register among N_REQ ATM front-end sessions (PIN-verified card controllers) and applies one deposit or withdrawal at a time, atomically. Sits between the per-terminal session FSMs and the balance store. Round-robin grant, registered result flags, one transaction per 3 cycles.

---
 rtl/atm_balance_arbiter_pkg.sv | 19 +
 rtl/atm_balance_arbiter_if.sv | 35 +++
 rtl/atm_balance_arbiter_rr.sv | 32 +++
 rtl/atm_balance_arbiter.sv | 111 +++++++++++
 tb/tb_atm_balance_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_balance_arbiter_pkg.sv
// Shared types and defaults for the ATM balance arbiter.
// States, transaction type codes and default widths.
package atm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic DEPOSITO = 1'b0;
   localparam logic RETIRO   = 1'b1;

   localparam int AMT_W_DEF = 32;
   localparam int BAL_W_DEF = 64;

   localparam logic [63:0] INIT_BALANCE_DEF = 64'd150000;

endpackage

// File: rtl/atm_balance_arbiter_if.sv
// Session-side bus of the ATM balance arbiter.
// master = sessions, slave = arbiter.
interface atm_balance_arbiter_if
   import atm_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int AMT_W = AMT_W_DEF,
   parameter int BAL_W = BAL_W_DEF
);

   logic [N_REQ-1:0]       REQ;
   logic [N_REQ-1:0]       TIPO;
   logic [N_REQ*AMT_W-1:0] MONTO;
   logic                   HOLD;
   logic [N_REQ-1:0]       GRANT;
   logic [N_REQ-1:0]       ACK;
   logic                   RES_OK;
   logic                   RES_INSUF;
   logic                   RES_OVF;
   logic [BAL_W-1:0]       BALANCE;
   logic                   BUSY;

   modport master (
      output REQ, TIPO, MONTO, HOLD,
      input  GRANT, ACK, RES_OK, RES_INSUF,
      input  RES_OVF, BALANCE, BUSY
   );

   modport slave (
      input  REQ, TIPO, MONTO, HOLD,
      output GRANT, ACK, RES_OK, RES_INSUF,
      output RES_OVF, BALANCE, BUSY
   );

endinterface

// File: rtl/atm_balance_arbiter_rr.sv
// Combinational round-robin pick: first request at or after ptr.
// Search wraps modulo N_REQ.
module rr_arbiter #(
   parameter  int N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   int c;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      c   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         c = int'(ptr) + k;
         if (c >= N_REQ) c = c - N_REQ;
         if (!any && req[c]) begin
            any    = 1'b1;
            gnt[c] = 1'b1;
            idx    = IDX_W'(c);
         end
      end
   end

endmodule

// File: rtl/atm_balance_arbiter.sv
// Atomic deposit/withdrawal on one shared balance, round-robin
// among N_REQ sessions, one transaction every 3 cycles.
module atm_balance_arbiter
   import atm_pkg::*;
#(
   parameter int               N_REQ        = 4,
   parameter int               AMT_W        = AMT_W_DEF,
   parameter int               BAL_W        = BAL_W_DEF,
   parameter logic [BAL_W-1:0] INIT_BALANCE = INIT_BALANCE_DEF
) (
   input logic                  CLK,
   input logic                  RESET,
   atm_balance_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(N_REQ);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, w_q, idx;
   logic [N_REQ-1:0] gnt, grant_q, ack_q;
   logic             any, tipo_q;
   logic [AMT_W-1:0] monto_q, monto_sel;
   logic [BAL_W-1:0] bal_q, mz, diff;
   logic [BAL_W:0]   sum;
   logic             ok_q, insuf_q, ovf_q, insuf;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req (bus.REQ),
      .ptr (ptr_q),
      .gnt (gnt),
      .idx (idx),
      .any (any)
   );

   always_comb begin
      state_d   = state_q;
      monto_sel = bus.MONTO[int'(idx)*AMT_W +: AMT_W];
      mz        = {{(BAL_W-AMT_W){1'b0}}, monto_q};
      sum       = {1'b0, bal_q} + {1'b0, mz};
      diff      = bal_q - mz;
      insuf     = mz > bal_q;
      unique case (state_q)
         IDLE:    if (!bus.HOLD && any) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ptr_q   <= '0;
         w_q     <= '0;
         tipo_q  <= DEPOSITO;
         monto_q <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         ok_q    <= 1'b0;
         insuf_q <= 1'b0;
         ovf_q   <= 1'b0;
         bal_q   <= INIT_BALANCE;
      end else begin
         unique case (state_q)
            IDLE: if (state_d == EXEC) begin
               w_q     <= idx;
               tipo_q  <= bus.TIPO[idx];
               monto_q <= monto_sel;
               grant_q <= gnt;
            end
            EXEC: begin
               ack_q <= grant_q;
               if (tipo_q == RETIRO) begin
                  if (insuf) insuf_q <= 1'b1;
                  else begin
                     bal_q <= diff;
                     ok_q  <= 1'b1;
                  end
               // carry out of BAL_W bits means overflow
               end else if (sum[BAL_W]) ovf_q <= 1'b1;
               else begin
                  bal_q <= sum[BAL_W-1:0];
                  ok_q  <= 1'b1;
               end
            end
            RESP: begin
               ack_q   <= '0;
               grant_q <= '0;
               ok_q    <= 1'b0;
               insuf_q <= 1'b0;
               ovf_q   <= 1'b0;
               ptr_q   <= (int'(w_q) == N_REQ-1) ? '0 : w_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.GRANT     = grant_q;
   assign bus.ACK       = ack_q;
   assign bus.RES_OK    = ok_q;
   assign bus.RES_INSUF = insuf_q;
   assign bus.RES_OVF   = ovf_q;
   assign bus.BALANCE   = bal_q;
   assign bus.BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_atm_balance_arbiter.sv
// Bench: two arbiters (normal and near-max balance) fed the same
// sessions, checked against a transaction-level model.
module tb_atm_balance_arbiter;
   import atm_pkg::*;

   localparam int N = 4;
   localparam int AW = 32;
   localparam int BW = 64;
   localparam logic [63:0] INIT_A = 64'd150000;
   localparam logic [63:0] INIT_B = 64'hFFFF_FFFF_FFFF_FFF6;

   logic clk = 1'b0;
   logic rst_n;
   logic [N-1:0] req, tipo;
   logic [N*AW-1:0] monto;
   logic hold;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] m_bal_a, m_bal_b;
   int m_ptr;

   always #5 clk = ~clk;

   atm_balance_arbiter_if #(.N_REQ(N), .AMT_W(AW), .BAL_W(BW)) bus_a ();
   atm_balance_arbiter_if #(.N_REQ(N), .AMT_W(AW), .BAL_W(BW)) bus_b ();

   assign bus_a.REQ = req;
   assign bus_a.TIPO = tipo;
   assign bus_a.MONTO = monto;
   assign bus_a.HOLD = hold;
   assign bus_b.REQ = req;
   assign bus_b.TIPO = tipo;
   assign bus_b.MONTO = monto;
   assign bus_b.HOLD = hold;

   atm_balance_arbiter #(
      .N_REQ(N), .AMT_W(AW), .BAL_W(BW), .INIT_BALANCE(INIT_A)
   ) dut_a (.CLK(clk), .RESET(rst_n), .bus(bus_a));

   atm_balance_arbiter #(
      .N_REQ(N), .AMT_W(AW), .BAL_W(BW), .INIT_BALANCE(INIT_B)
   ) dut_b (.CLK(clk), .RESET(rst_n), .bus(bus_b));

   // Reference: account arithmetic done in 65 bits.
   task automatic model_apply(
      input  logic [63:0] bal, input logic t, input logic [31:0] m,
      output logic [2:0] flags, output logic [63:0] nb);
      logic [64:0] s;
      nb = bal;
      if (t == RETIRO) begin
         if ({32'd0, m} > bal) flags = 3'b010;
         else begin nb = bal - {32'd0, m}; flags = 3'b100; end
      end else begin
         s = {1'b0, bal} + {33'd0, m};
         if (s > {1'b0, {64{1'b1}}}) flags = 3'b001;
         else begin nb = s[63:0]; flags = 3'b100; end
      end
   endtask

   task automatic set_slot(input int i, input logic t, input logic [31:0] m);
      tipo[i] = t;
      monto[i*AW +: AW] = m;
   endtask

   function automatic logic [31:0] rand_amt();
      case ($urandom % 4)
         0: return 32'd0;
         1: return 32'($urandom % 1000);
         2: return 32'($urandom_range(140000, 160000));
         default: return $urandom;
      endcase
   endfunction

   task automatic do_reset(input logic [N-1:0] mask);
      rst_n = 1'b0;
      req = mask;
      hold = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_bal_a = INIT_A;
      m_bal_b = INIT_B;
      m_ptr = 0;
   endtask

   // Entered at a negedge with the arbiter idle and req != 0.
   task automatic serve_one(input bit early, output logic [N-1:0] g);
      int w;
      logic t;
      logic [31:0] m;
      logic [2:0] fa, fb, ga, gb;
      logic [63:0] nb;
      w = -1;
      for (int k = 0; k < N; k++)
         if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      g = '0;
      if (w < 0) return;
      t = tipo[w];
      m = monto[w*AW +: AW];
      @(negedge clk);
      g = bus_a.GRANT;
      n_cmp++;
      if (bus_a.GRANT !== N'(1 << w)) begin
         n_bad++;
         $display("FAIL grant_a got %b want %b", bus_a.GRANT, N'(1 << w));
      end
      n_cmp++;
      if (bus_b.GRANT !== N'(1 << w)) begin
         n_bad++;
         $display("FAIL grant_b got %b want %b", bus_b.GRANT, N'(1 << w));
      end
      n_cmp++;
      if ({bus_a.BUSY, bus_a.ACK} !== {1'b1, N'(0)}) begin
         n_bad++;
         $display("FAIL exec_busy_ack got %b/%b want 1/0",
                  bus_a.BUSY, bus_a.ACK);
      end
      if (early) req[w] = 1'b0;
      @(negedge clk);
      model_apply(m_bal_a, t, m, fa, nb);
      m_bal_a = nb;
      model_apply(m_bal_b, t, m, fb, nb);
      m_bal_b = nb;
      ga = {bus_a.RES_OK, bus_a.RES_INSUF, bus_a.RES_OVF};
      gb = {bus_b.RES_OK, bus_b.RES_INSUF, bus_b.RES_OVF};
      n_cmp++;
      if (bus_a.ACK !== N'(1 << w) || bus_b.ACK !== N'(1 << w)) begin
         n_bad++;
         $display("FAIL ack got %b/%b want %b",
                  bus_a.ACK, bus_b.ACK, N'(1 << w));
      end
      n_cmp++;
      if (ga !== fa) begin
         n_bad++;
         $display("FAIL flags_a got %b want %b (t=%b m=%0d)", ga, fa, t, m);
      end
      n_cmp++;
      if (gb !== fb) begin
         n_bad++;
         $display("FAIL flags_b got %b want %b (t=%b m=%0d)", gb, fb, t, m);
      end
      n_cmp++;
      if (bus_a.BALANCE !== m_bal_a) begin
         n_bad++;
         $display("FAIL bal_a got %0d want %0d", bus_a.BALANCE, m_bal_a);
      end
      n_cmp++;
      if (bus_b.BALANCE !== m_bal_b) begin
         n_bad++;
         $display("FAIL bal_b got %0d want %0d", bus_b.BALANCE, m_bal_b);
      end
      req[w] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus_a.ACK, bus_a.GRANT, bus_a.BUSY, bus_a.RES_OK,
           bus_a.RES_INSUF, bus_a.RES_OVF} !== '0) begin
         n_bad++;
         $display("FAIL resp_clear got ack=%b gnt=%b busy=%b flags=%b want 0",
                  bus_a.ACK, bus_a.GRANT, bus_a.BUSY,
                  {bus_a.RES_OK, bus_a.RES_INSUF, bus_a.RES_OVF});
      end
      m_ptr = (w + 1) % N;
   endtask

   task automatic test_reset();
      do_reset('0);
      @(negedge clk);
      n_cmp++;
      if ({bus_a.GRANT, bus_a.ACK, bus_a.BUSY, bus_a.RES_OK,
           bus_a.RES_INSUF, bus_a.RES_OVF} !== '0) begin
         n_bad++;
         $display("FAIL reset_outs got gnt=%b ack=%b busy=%b want 0",
                  bus_a.GRANT, bus_a.ACK, bus_a.BUSY);
      end
      n_cmp++;
      if (bus_a.BALANCE !== INIT_A || bus_b.BALANCE !== INIT_B) begin
         n_bad++;
         $display("FAIL reset_bal got %0d/%0d want %0d/%0d",
                  bus_a.BALANCE, bus_b.BALANCE, INIT_A, INIT_B);
      end
   endtask

   task automatic test_deposit();
      logic [N-1:0] g;
      do_reset('0);
      set_slot(0, DEPOSITO, 32'd5000);
      req = 4'b0001;
      serve_one(1'b0, g);
      n_cmp++;
      if (bus_a.BALANCE !== 64'd155000) begin
         n_bad++;
         $display("FAIL dep5000 got %0d want 155000", bus_a.BALANCE);
      end
      set_slot(2, DEPOSITO, 32'd0);
      req = 4'b0100;
      serve_one(1'b0, g);
   endtask

   task automatic test_withdraw();
      logic [N-1:0] g;
      do_reset('0);
      set_slot(1, RETIRO, 32'd150001);
      req = 4'b0010;
      serve_one(1'b0, g);
      set_slot(1, RETIRO, 32'd150000);
      req = 4'b0010;
      serve_one(1'b1, g);
      n_cmp++;
      if (bus_a.BALANCE !== 64'd0) begin
         n_bad++;
         $display("FAIL wd_all got %0d want 0", bus_a.BALANCE);
      end
   endtask

   task automatic test_overflow();
      logic [N-1:0] g;
      do_reset('0);
      set_slot(0, DEPOSITO, 32'd10);
      req = 4'b0001;
      serve_one(1'b0, g);
      set_slot(0, DEPOSITO, 32'd9);
      req = 4'b0001;
      serve_one(1'b0, g);
      n_cmp++;
      if (bus_b.BALANCE !== {64{1'b1}}) begin
         n_bad++;
         $display("FAIL ovf_max got %h want all ones", bus_b.BALANCE);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] g0, g1, g2;
      for (int i = 0; i < 3; i++) set_slot(i, DEPOSITO, 32'(i + 1));
      do_reset(4'b0111);
      serve_one(1'b0, g0);
      serve_one(1'b0, g1);
      serve_one(1'b0, g2);
      n_cmp++;
      if ({g0, g1, g2} !== {4'b0001, 4'b0010, 4'b0100}) begin
         n_bad++;
         $display("FAIL rr_order got %b,%b,%b want 0001,0010,0100",
                  g0, g1, g2);
      end
   endtask

   task automatic test_hold();
      logic [N-1:0] g;
      do_reset('0);
      set_slot(3, DEPOSITO, 32'd7);
      hold = 1'b1;
      req = 4'b1000;
      repeat (5) begin
         @(negedge clk);
         n_cmp++;
         if (bus_a.GRANT !== '0 || bus_a.BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_block got gnt=%b busy=%b want 0/0",
                     bus_a.GRANT, bus_a.BUSY);
         end
      end
      hold = 1'b0;
      serve_one(1'b0, g);
      n_cmp++;
      if (g !== 4'b1000) begin
         n_bad++;
         $display("FAIL hold_release got %b want 1000", g);
      end
   endtask

   task automatic test_reset_mid();
      do_reset('0);
      set_slot(2, RETIRO, 32'd1000);
      req = 4'b0100;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus_a.GRANT !== '0 || bus_a.BUSY !== 1'b0 || bus_a.ACK !== '0) begin
         n_bad++;
         $display("FAIL rst_mid_ctl got gnt=%b busy=%b ack=%b want 0",
                  bus_a.GRANT, bus_a.BUSY, bus_a.ACK);
      end
      n_cmp++;
      if (bus_a.BALANCE !== INIT_A) begin
         n_bad++;
         $display("FAIL rst_mid_bal got %0d want %0d", bus_a.BALANCE, INIT_A);
      end
      @(negedge clk);
      n_cmp++;
      if (bus_a.ACK !== '0) begin
         n_bad++;
         $display("FAIL rst_mid_ack got %b want 0", bus_a.ACK);
      end
      req = '0;
      rst_n = 1'b1;
      m_bal_a = INIT_A;
      m_bal_b = INIT_B;
      m_ptr = 0;
   endtask

   task automatic test_random();
      logic [N-1:0] g;
      do_reset('0);
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++)
            if (!req[i] && ($urandom % 2 == 1)) begin
               set_slot(i, 1'($urandom % 2), rand_amt());
               req[i] = 1'b1;
            end
         if (req == '0) begin
            set_slot(0, 1'($urandom % 2), rand_amt());
            req[0] = 1'b1;
         end
         if ($urandom % 5 == 0) begin
            hold = 1'b1;
            repeat (1 + $urandom % 3) begin
               @(negedge clk);
               n_cmp++;
               if (bus_a.GRANT !== '0) begin
                  n_bad++;
                  $display("FAIL rnd_hold got %b want 0", bus_a.GRANT);
               end
            end
            hold = 1'b0;
         end
         serve_one(($urandom % 4) == 0, g);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req = '0;
      tipo = '0;
      monto = '0;
      hold = 1'b0;
      test_reset();
      test_deposit();
      test_withdraw();
      test_overflow();
      test_round_robin();
      test_hold();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
